// File: rtl/sel_mux_pipe_if.sv
// Handshake bundle for sel_mux_pipe: flattened word bus and select in, selected word out.
// result_idx exists only when SEL_MUX_PIPE_IDX_EN is defined.
interface sel_mux_pipe_if #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 128
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*DATA_W-1:0] data_in;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        result;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_oor;
`ifdef SEL_MUX_PIPE_IDX_EN
    logic [SEL_W-1:0]         result_idx;
`endif

    modport master (
        output data_in, sel, in_valid, out_ready,
`ifdef SEL_MUX_PIPE_IDX_EN
        input  result_idx,
`endif
        input  in_ready, result, out_valid, out_oor
    );

    modport slave (
        input  data_in, sel, in_valid, out_ready,
`ifdef SEL_MUX_PIPE_IDX_EN
        output result_idx,
`endif
        output in_ready, result, out_valid, out_oor
    );
endinterface

// File: rtl/sel_mux_pipe.sv
// Pipelined RADIX-ary N:1 word selector, flags sel >= NUM_IN (result forced to 0).
// Latency LEVELS cycles, 1 beat/cycle; whole pipe holds while out_valid && !out_ready.
// Optional SEL_MUX_PIPE_IDX_EN adds result_idx carrying each beat's original sel.
module sel_mux_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 128,
    parameter int RADIX  = 4
) (
    input  logic          clock,
    input  logic          aclr,
    sel_mux_pipe_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int LOG_R  = $clog2(RADIX);
    localparam int LEVELS = (SEL_W + LOG_R - 1) / LOG_R;
    localparam int PAD_N  = RADIX ** LEVELS;
    localparam int PAD_W  = PAD_N * DATA_W;
    localparam int SELP_W = LEVELS * LOG_R;
    localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_IN);

    logic              advance;
    logic              in_oor;
    logic [SELP_W-1:0] sel_pad;
    logic [PAD_W-1:0]  data_pad;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Padding words are zero; an out-of-range beat zeroes the whole tree input.
    assign in_oor   = {1'b0, bus.sel} >= LIMIT;
    assign sel_pad  = SELP_W'(bus.sel);
    assign data_pad = in_oor ? '0 : PAD_W'(bus.data_in);

    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int IN_N  = RADIX ** (LEVELS - k);
        localparam int OUT_N = IN_N / RADIX;
        localparam int SR_W  = (LEVELS - k) * LOG_R;
        localparam int REM_W = SR_W - LOG_R;
        localparam bit LAST  = (k == LEVELS - 1);

        logic [IN_N*DATA_W-1:0]  src_words;
        logic [SR_W-1:0]         src_sel;
        logic                    src_vld;
        logic                    src_oor;
        logic [OUT_N*DATA_W-1:0] mux_words;
        logic [OUT_N*DATA_W-1:0] words_q;
        logic                    vld_q;
        logic                    oor_q;

        if (k == 0) begin : g_head
            assign src_words = data_pad;
            assign src_sel   = sel_pad;
            assign src_vld   = bus.in_valid;
            assign src_oor   = in_oor;
        end else begin : g_link
            assign src_words = lvl[k-1].words_q;
            assign src_sel   = lvl[k-1].g_rem.sel_q;
            assign src_vld   = lvl[k-1].vld_q;
            assign src_oor   = lvl[k-1].oor_q;
        end

        // Low select bits pick one word out of each group of RADIX neighbours.
        always_comb begin
            mux_words = '0;
            for (int j = 0; j < OUT_N; j++) begin
                mux_words[j*DATA_W +: DATA_W] =
                    src_words[(j*RADIX + int'(src_sel[LOG_R-1:0]))*DATA_W +: DATA_W];
            end
        end

        if (REM_W > 0) begin : g_rem
            logic [REM_W-1:0] sel_q;
            always_ff @(posedge clock) begin
                if (advance) sel_q <= src_sel[SR_W-1:LOG_R];
            end
        end

        // The output stage only loads real beats so result holds across bubbles.
        always_ff @(posedge clock) begin
            if (aclr) begin
                vld_q   <= 1'b0;
                oor_q   <= 1'b0;
                words_q <= '0;
            end else if (advance) begin
                vld_q <= src_vld;
                if (src_vld || !LAST) begin
                    words_q <= mux_words;
                    oor_q   <= src_oor;
                end
            end
        end

`ifdef SEL_MUX_PIPE_IDX_EN
        logic [SEL_W-1:0] src_idx;
        logic [SEL_W-1:0] idx_q;

        if (k == 0) begin : g_idx_head
            assign src_idx = bus.sel;
        end else begin : g_idx_link
            assign src_idx = lvl[k-1].idx_q;
        end

        always_ff @(posedge clock) begin
            if (aclr) begin
                idx_q <= '0;
            end else if (advance && (src_vld || !LAST)) begin
                idx_q <= src_idx;
            end
        end
`endif
    end

    assign bus.result    = lvl[LEVELS-1].words_q;
    assign bus.out_valid = lvl[LEVELS-1].vld_q;
    assign bus.out_oor   = lvl[LEVELS-1].oor_q;
`ifdef SEL_MUX_PIPE_IDX_EN
    assign bus.result_idx = lvl[LEVELS-1].idx_q;
`endif
endmodule
